// File: rtl/mem_access_lsu.sv
// Load/store unit between the pipeline and the memory access controller.
// Handles byte/half/word alignment, store lane replication and load extension.
module mem_access_lsu #(
    parameter bit MISALIGN_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_cmd_start,
    output logic        mem_cmd_write,
    input  logic        mem_cmd_ready,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_wmask
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t      state_q, state_d;
    logic        ready_en_q, ready_en_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wmask_q, wmask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        misalign;
    logic        req_err;
    logic [1:0]  eff_off;
    logic [31:0] lane;

    always_comb begin
        accept   = (state_q == IDLE) && ready_en_q && req_valid;
        misalign = ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        req_err  = (req_size == 2'b11) || (MISALIGN_ERR && misalign);
        // Offset after forcing alignment; identical to addr[1:0] for aligned requests.
        case (req_size)
            2'b00:   eff_off = req_addr[1:0];
            2'b01:   eff_off = {req_addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
        lane = mem_rdata >> {off_q, 3'b000};
    end

    always_comb begin
        state_d    = state_q;
        ready_en_d = 1'b1;
        write_d    = write_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = eff_off;
                    err_d   = req_err;
                    rdata_d = 32'h0;
                    addr_d  = {req_addr[31:2], 2'b00};
                    write_d = req_write && !req_err;
                    case (req_size)
                        2'b00: begin
                            wdata_d = {4{req_wdata[7:0]}};
                            wmask_d = 32'h0000_00FF << {eff_off, 3'b000};
                        end
                        2'b01: begin
                            wdata_d = {2{req_wdata[15:0]}};
                            wmask_d = 32'h0000_FFFF << {eff_off[1], 4'b0000};
                        end
                        default: begin
                            wdata_d = req_wdata;
                            wmask_d = 32'hFFFF_FFFF;
                        end
                    endcase
                    if (!req_write || req_err) begin
                        wmask_d = 32'h0;
                    end
                    state_d = req_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_cmd_ready) begin
                    state_d = write_q ? RESP : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mem_rdata_valid) begin
                    case (size_q)
                        2'b00:   rdata_d = {{24{lane[7] & ~uns_q}}, lane[7:0]};
                        2'b01:   rdata_d = {{16{lane[15] & ~uns_q}}, lane[15:0]};
                        default: rdata_d = lane;
                    endcase
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_en_q <= 1'b0;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wmask_q    <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= ready_en_d;
            write_q    <= write_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign req_ready     = (state_q == IDLE) && ready_en_q;
    assign resp_valid    = (state_q == RESP);
    assign resp_error    = (state_q == RESP) && err_q;
    assign resp_rdata    = rdata_q;
    assign mem_cmd_start = (state_q == ISSUE);
    assign mem_cmd_write = write_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

endmodule

// File: tb/tb_mem_access_lsu.sv
// Directed bench for mem_access_lsu: stores, loads, errors, backpressure and reset.
module tb_mem_access_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        mem_cmd_start, mem_cmd_write, mem_cmd_ready, mem_rdata_valid;
    logic [31:0] mem_addr, mem_rdata, mem_wdata, mem_wmask;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cmds   = 0;
    int n_resps  = 0;
    int n_accept = 0;
    int n_starts = 0;

    always #5 clk = ~clk;

    mem_access_lsu #(.MISALIGN_ERR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write),
        .mem_cmd_ready(mem_cmd_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
    );

    always @(posedge clk) begin
        if (mem_cmd_start && mem_cmd_ready) n_cmds++;
        if (mem_cmd_start) n_starts++;
        if (resp_valid) n_resps++;
        if (req_valid && req_ready) n_accept++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic w, input logic [31:0] a, input logic [1:0] sz,
                             input logic uns, input logic [31:0] wd);
        req_valid = 1'b1; req_write = w; req_addr = a;
        req_size = sz; req_unsigned = uns; req_wdata = wd;
        check_eq("ready_before_accept", {31'b0, req_ready}, 32'd1);
        step;
        req_valid = 1'b0;
    endtask

    // Called one cycle after the accept edge; returns cycles from accept, -1 on timeout.
    task automatic wait_resp(input int max, output int lat);
        lat = 1;
        while (!resp_valid && lat < max) begin
            step;
            lat++;
        end
        if (!resp_valid) lat = -1;
    endtask

    initial begin
        int lat;
        int c0, r0, s0, a0;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'h0;
        mem_cmd_ready = 1'b0; mem_rdata = 32'h0; mem_rdata_valid = 1'b0;

        #3;
        check_eq("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_eq("rst_cmd_start", {31'b0, mem_cmd_start}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wmask", mem_wmask, 32'h0);
        #9;
        rst_n = 1'b1;
        #1;
        check_eq("ready_before_first_edge", {31'b0, req_ready}, 32'd0);
        step;
        check_eq("ready_after_release", {31'b0, req_ready}, 32'd1);

        // Byte store at 0x103
        mem_cmd_ready = 1'b1;
        do_accept(1'b1, 32'h103, 2'b00, 1'b0, 32'h0000_00A5);
        check_eq("bst_start", {31'b0, mem_cmd_start}, 32'd1);
        check_eq("bst_write", {31'b0, mem_cmd_write}, 32'd1);
        check_eq("bst_addr", mem_addr, 32'h100);
        check_eq("bst_wdata", mem_wdata, 32'hA5A5A5A5);
        check_eq("bst_wmask", mem_wmask, 32'hFF000000);
        wait_resp(10, lat);
        check_eq("bst_latency", lat, 32'd2);
        check_eq("bst_err", {31'b0, resp_error}, 32'd0);
        check_eq("bst_rdata", resp_rdata, 32'h0);
        step;
        check_eq("bst_idle_ready", {31'b0, req_ready}, 32'd1);
        check_eq("bst_idle_resp", {31'b0, resp_valid}, 32'd0);
        $display("txn byte store addr=0x103 latency=%0d", lat);

        // Half stores in both halves
        do_accept(1'b1, 32'h206, 2'b01, 1'b0, 32'hDEAD_BEEF);
        check_eq("hst_wdata", mem_wdata, 32'hBEEFBEEF);
        check_eq("hst_wmask", mem_wmask, 32'hFFFF0000);
        wait_resp(10, lat);
        check_eq("hst_latency", lat, 32'd2);
        step;
        do_accept(1'b1, 32'h208, 2'b01, 1'b0, 32'h0000_1234);
        check_eq("hst0_wmask", mem_wmask, 32'h0000FFFF);
        wait_resp(10, lat);
        step;
        $display("txn half stores addr=0x206/0x208");

        // Signed half load at 0x202, rdata_valid held so it lands in the first WAIT_RD cycle
        mem_rdata = 32'h8001_1234; mem_rdata_valid = 1'b1;
        do_accept(1'b0, 32'h202, 2'b01, 1'b0, 32'h0);
        check_eq("hld_addr", mem_addr, 32'h200);
        check_eq("hld_wmask", mem_wmask, 32'h0);
        check_eq("hld_write", {31'b0, mem_cmd_write}, 32'd0);
        wait_resp(10, lat);
        check_eq("hld_latency", lat, 32'd3);
        check_eq("hld_signed", resp_rdata, 32'hFFFF8001);
        step;
        do_accept(1'b0, 32'h202, 2'b01, 1'b1, 32'h0);
        wait_resp(10, lat);
        check_eq("hld_unsigned", resp_rdata, 32'h00008001);
        step;
        $display("txn half loads addr=0x202 signed/unsigned");

        // Signed byte load at 0x301 and word load
        mem_rdata = 32'h0000_8000;
        do_accept(1'b0, 32'h301, 2'b00, 1'b0, 32'h0);
        wait_resp(10, lat);
        check_eq("bld_signed", resp_rdata, 32'hFFFFFF80);
        step;
        mem_rdata = 32'hCAFE_F00D;
        do_accept(1'b0, 32'h400, 2'b10, 1'b0, 32'h0);
        wait_resp(10, lat);
        check_eq("wld_data", resp_rdata, 32'hCAFEF00D);
        step;
        mem_rdata_valid = 1'b0;
        $display("txn byte/word loads");

        // Misaligned word load and illegal size
        s0 = n_starts;
        do_accept(1'b0, 32'h101, 2'b10, 1'b0, 32'h0);
        check_eq("mis_resp_valid", {31'b0, resp_valid}, 32'd1);
        check_eq("mis_error", {31'b0, resp_error}, 32'd1);
        check_eq("mis_rdata", resp_rdata, 32'h0);
        step;
        check_eq("mis_back_idle", {31'b0, req_ready}, 32'd1);
        do_accept(1'b1, 32'h100, 2'b11, 1'b0, 32'h0);
        check_eq("ill_error", {31'b0, resp_error}, 32'd1);
        step;
        check_eq("err_no_start", n_starts - s0, 32'd0);
        $display("txn misaligned word load and illegal size");

        // Backpressure on a word store
        mem_cmd_ready = 1'b0;
        c0 = n_cmds;
        do_accept(1'b1, 32'h44, 2'b10, 1'b0, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_start", {31'b0, mem_cmd_start}, 32'd1);
            check_eq("bp_addr", mem_addr, 32'h44);
            check_eq("bp_wmask", mem_wmask, 32'hFFFFFFFF);
            step;
        end
        mem_cmd_ready = 1'b1;
        check_eq("bp_start_last", {31'b0, mem_cmd_start}, 32'd1);
        step;
        check_eq("bp_resp", {31'b0, resp_valid}, 32'd1);
        step;
        check_eq("bp_cmd_count", n_cmds - c0, 32'd1);
        $display("txn backpressured word store, 5 stall cycles");

        // Reset while waiting for read data
        r0 = n_resps;
        do_accept(1'b0, 32'h301, 2'b00, 1'b0, 32'h0);
        step;
        rst_n = 1'b0;
        #1;
        check_eq("mr_ready_in_rst", {31'b0, req_ready}, 32'd0);
        check_eq("mr_addr_in_rst", mem_addr, 32'h0);
        mem_rdata_valid = 1'b1;
        step;
        rst_n = 1'b1;
        step;
        check_eq("mr_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_eq("mr_ready", {31'b0, req_ready}, 32'd1);
        step;
        check_eq("mr_no_resp", n_resps - r0, 32'd0);
        mem_rdata_valid = 1'b0;
        $display("txn reset during WAIT_RD");

        // Back-to-back stores with req_valid held high
        a0 = n_accept;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
        req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h5555_AAAA;
        step;
        check_eq("b2b_issue_ready", {31'b0, req_ready}, 32'd0);
        step;
        check_eq("b2b_resp", {31'b0, resp_valid}, 32'd1);
        check_eq("b2b_resp_ready", {31'b0, req_ready}, 32'd0);
        step;
        check_eq("b2b_idle_ready", {31'b0, req_ready}, 32'd1);
        check_eq("b2b_accepts_so_far", n_accept - a0, 32'd1);
        step;
        req_valid = 1'b0;
        check_eq("b2b_second_issue", {31'b0, mem_cmd_start}, 32'd1);
        check_eq("b2b_accepts", n_accept - a0, 32'd2);
        wait_resp(10, lat);
        check_eq("b2b_second_latency", lat, 32'd2);
        step;
        $display("txn back-to-back word stores");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_lsu.md
MEM_ACCESS_LSU -- requirements
Module: mem_access_lsu

Interface
REQ-001 The block SHALL have parameter MISALIGN_ERR, default 1: 1 = misaligned request reports error without memory access; 0 = address low bits forced to alignment.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid  input  1  pipeline load/store request present.
REQ-005 The block SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-006 The block SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port req_addr  input  32  byte address.
REQ-008 The block SHALL have port req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 The block SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 The block SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 The block SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-013 The block SHALL have port resp_error  output  1  misaligned or illegal size; qualified by resp_valid.
REQ-014 The block SHALL have ports mem_cmd_start (output 1), mem_cmd_write (output 1), mem_cmd_ready (input 1), mem_addr (output 32), mem_rdata (input 32), mem_rdata_valid (input 1), mem_wdata (output 32), and mem_wmask (output 32, per-bit write mask), all connecting to the memory access controller.

Function
REQ-015 The block SHALL use FSM states IDLE, ISSUE, WAIT_RD and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a cycle with req_valid=1 and req_ready=1.
REQ-017 On accept, the block SHALL register all req_* fields; the request SHALL be misaligned if (size=01 and addr[0]) or (size=10 and addr[1:0]!=0), and size=11 SHALL always be an error.
REQ-018 On an error with MISALIGN_ERR=1, IDLE SHALL go to RESP with resp_error=1, and mem_cmd_start SHALL never be asserted for that request.
REQ-019 Otherwise IDLE SHALL go to ISSUE, with mem_addr = {addr[31:2],2'b00}.
REQ-020 In ISSUE, mem_cmd_start SHALL be held at 1 with stable mem_addr, mem_cmd_write, mem_wdata and mem_wmask until a cycle where mem_cmd_ready=1, at which the command is taken.
REQ-021 When a store command is taken, the block SHALL go ISSUE -> RESP; when a load command is taken, it SHALL go ISSUE -> WAIT_RD.
REQ-022 Store data SHALL be lane-replicated: for a byte, mem_wdata = {4{wdata[7:0]}} and mem_wmask = 0xFF << (8*addr[1:0]); for a half, mem_wdata = {2{wdata[15:0]}} and mem_wmask = 0xFFFF << (16*addr[1]); for a word, mem_wmask = 0xFFFFFFFF.
REQ-023 For loads, mem_wmask SHALL be 0 and mem_cmd_write SHALL be 0.
REQ-024 In WAIT_RD, the block SHALL capture mem_rdata in the cycle mem_rdata_valid=1 and go to RESP; mem_rdata_valid SHALL be ignored in all other states.
REQ-025 The load result SHALL be taken from lane (mem_rdata >> 8*addr[1:0]) and extended per size and req_unsigned.
REQ-026 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE, and a new request SHALL NOT be accepted in the RESP cycle.
REQ-027 Minimum latency (accept -> resp_valid) SHALL be 2 cycles for a store and 3 cycles for a load, both with zero memory wait.
REQ-028 mem_cmd_start SHALL be 0 in every state except ISSUE.

Reset
REQ-029 While rst_n=0, the block SHALL immediately force state to IDLE and set req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0, mem_cmd_start=0, mem_cmd_write=0, mem_addr=0, mem_wdata=0 and mem_wmask=0.
REQ-030 req_ready SHALL be 1 from the first clock edge after rst_n rises.
REQ-031 Reset asserted mid-operation (ISSUE or WAIT_RD) SHALL abandon the request with no resp_valid, and a late mem_rdata_valid afterward SHALL be ignored.

Verification
REQ-032 Byte store: addr=0x103, wdata=0xA5, memory ready immediately -> mem_wdata=0xA5A5A5A5, mem_wmask=0xFF000000, resp_valid 2 cycles after accept.
REQ-033 Signed half load: addr=0x202, mem_rdata=0x8001_1234 -> resp_rdata=0xFFFF8001; with req_unsigned=1 -> resp_rdata=0x00008001.
REQ-034 Misaligned word load: addr=0x101 -> resp_error=1 with mem_cmd_start never asserted, and the next cycle returns to IDLE.
REQ-035 Backpressure: mem_cmd_ready held 0 for 5 cycles -> mem_cmd_start stays 1 with stable mem_addr/mem_wmask, and exactly one command is taken.
REQ-036 Reset in WAIT_RD followed by mem_rdata_valid=1 -> no resp_valid, and req_ready=1 after reset release.
REQ-037 Back-to-back requests with req_valid held 1 -> the second request is accepted only in the IDLE cycle following RESP.
